// File: rtl/instruction_fetch_pc_control_pkg.sv
// Shared definitions for the IF-stage PC / IF-ID controller:
// fetch state encoding, NOP word and default HALT encoding.
package instruction_fetch_pc_control_pkg;

    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTRUCCION          = '0;
    localparam logic [31:0] HALT_INSTRUCCION_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/instruction_fetch_pc_control_adder_signed.sv
// Fixed-width address adder; the sum wraps modulo 2^N_BITS.
module adder_signed #(
    parameter int unsigned N_BITS = 11
) (
    input  logic [N_BITS-1:0] i_a,
    input  logic [N_BITS-1:0] i_b,
    output logic [N_BITS-1:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/instruction_fetch_pc_control.sv
// IF-stage program counter and IF/ID pipeline register with branch flush,
// hazard stall, debug enable and HALT detection.
module instruction_fetch_pc_control
    import instruction_fetch_pc_control_pkg::*;
#(
    parameter int unsigned                     CANT_BITS_ADDR        = 11,
    parameter int unsigned                     CANT_BITS_INSTRUCCION = 32,
    parameter logic [CANT_BITS_INSTRUCCION-1:0] HALT_INSTRUCCION     =
        CANT_BITS_INSTRUCCION'(HALT_INSTRUCCION_DEFAULT)
) (
    input  logic                             i_clock,
    input  logic                             i_reset,
    input  logic                             i_enable,
    input  logic                             i_stall,
    input  logic                             i_branch_control,
    input  logic [CANT_BITS_ADDR-1:0]        i_branch_dir,
    input  logic [CANT_BITS_INSTRUCCION-1:0] i_instruccion,
    output logic [CANT_BITS_ADDR-1:0]        o_pc,
    output logic                             o_enable_mem,
    output logic [CANT_BITS_INSTRUCCION-1:0] o_instruccion,
    output logic [CANT_BITS_ADDR-1:0]        o_adder_pc,
    output logic                             o_valid,
    output logic                             o_halt
);

    localparam logic [CANT_BITS_ADDR-1:0]        ADDR_ONE = CANT_BITS_ADDR'(1);
    localparam logic [CANT_BITS_INSTRUCCION-1:0] NOP_WORD =
        CANT_BITS_INSTRUCCION'(NOP_INSTRUCCION);

    fetch_state_t                     r_state;
    logic [CANT_BITS_ADDR-1:0]        r_pc;
    logic [CANT_BITS_ADDR-1:0]        r_fetch_pc;
    logic [CANT_BITS_INSTRUCCION-1:0] r_instruccion;
    logic [CANT_BITS_ADDR-1:0]        r_adder_pc;
    logic                             r_valid;

    fetch_state_t                     w_state_next;
    logic [CANT_BITS_ADDR-1:0]        w_pc_next;
    logic [CANT_BITS_ADDR-1:0]        w_fetch_pc_next;
    logic [CANT_BITS_INSTRUCCION-1:0] w_instruccion_next;
    logic [CANT_BITS_ADDR-1:0]        w_adder_pc_next;
    logic                             w_valid_next;

    logic [CANT_BITS_ADDR-1:0]        w_pc_inc;
    logic [CANT_BITS_ADDR-1:0]        w_fetch_pc_inc;
    logic                             w_advance;
    logic                             w_is_halt;

    adder_signed #(
        .N_BITS (CANT_BITS_ADDR)
    ) u_adder_pc (
        .i_a   (r_pc),
        .i_b   (ADDR_ONE),
        .o_sum (w_pc_inc)
    );

    adder_signed #(
        .N_BITS (CANT_BITS_ADDR)
    ) u_adder_fetch_pc (
        .i_a   (r_fetch_pc),
        .i_b   (ADDR_ONE),
        .o_sum (w_fetch_pc_inc)
    );

    assign w_advance = i_enable & ~i_stall & (r_state != ST_HALT);
    assign w_is_halt = (i_instruccion == HALT_INSTRUCCION);

    // Memory must not capture a new address while reset is held.
    assign o_enable_mem  = w_advance & i_reset;
    assign o_pc          = r_pc;
    assign o_instruccion = r_instruccion;
    assign o_adder_pc    = r_adder_pc;
    assign o_valid       = r_valid;
    assign o_halt        = (r_state == ST_HALT);

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_fetch_pc_next    = r_fetch_pc;
        w_instruccion_next = r_instruccion;
        w_adder_pc_next    = r_adder_pc;
        w_valid_next       = r_valid;

        if (w_advance) begin
            case (r_state)
                ST_FLUSH: begin
                    w_instruccion_next = NOP_WORD;
                    w_adder_pc_next    = '0;
                    w_valid_next       = 1'b0;
                    w_fetch_pc_next    = r_pc;
                    w_pc_next          = w_pc_inc;
                    w_state_next       = ST_RUN;
                end
                ST_RUN: begin
                    if (i_branch_control) begin
                        // Word on i_instruccion is wrong-path; squash it even if it is HALT.
                        w_instruccion_next = NOP_WORD;
                        w_adder_pc_next    = '0;
                        w_valid_next       = 1'b0;
                        w_pc_next          = i_branch_dir;
                        w_state_next       = ST_FLUSH;
                    end else if (w_is_halt) begin
                        w_instruccion_next = i_instruccion;
                        w_adder_pc_next    = w_fetch_pc_inc;
                        w_valid_next       = 1'b1;
                        w_state_next       = ST_HALT;
                    end else begin
                        w_instruccion_next = i_instruccion;
                        w_adder_pc_next    = w_fetch_pc_inc;
                        w_valid_next       = 1'b1;
                        w_fetch_pc_next    = r_pc;
                        w_pc_next          = w_pc_inc;
                    end
                end
                default: ;
            endcase
        end else if (i_enable && (r_state == ST_HALT)) begin
            w_instruccion_next = NOP_WORD;
            w_adder_pc_next    = '0;
            w_valid_next       = 1'b0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= ST_FLUSH;
            r_pc          <= '0;
            r_fetch_pc    <= '0;
            r_instruccion <= '0;
            r_adder_pc    <= '0;
            r_valid       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_instruccion <= w_instruccion_next;
            r_adder_pc    <= w_adder_pc_next;
            r_valid       <= w_valid_next;
        end
    end

endmodule

// File: doc/instruction_fetch_pc_control.md
# instruction_fetch_pc_control

IF-stage program-counter and IF/ID pipeline-register controller of the MIPS pipeline.
- Drives the synchronous instruction-memory address and captures the returned instruction together with its PC+1 into IF/ID.
- Consumes the taken-branch decision and target computed by the ID-stage branch address calculator; a taken branch costs exactly two squashed slots.
- Handles hazard-unit stalls, debug-unit stepping, and the HALT instruction.

## Interface
Parameters:
- CANT_BITS_ADDR, 11, PC / instruction-memory address width
- CANT_BITS_INSTRUCCION, 32, instruction width
- HALT_INSTRUCCION, 32'hFFFFFFFF, encoding that stops fetch

Ports:
- i_clock  in  1  single clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  debug-unit step/run enable; 0 freezes the whole block
- i_stall  in  1  hazard-unit stall; holds PC, IF/ID and state
- i_branch_control  in  1  taken branch/jump resolved in ID this cycle
- i_branch_dir  in  CANT_BITS_ADDR  branch target
- i_instruccion  in  CANT_BITS_INSTRUCCION  instruction-memory read data; 1-cycle latency after address
- o_pc  out  CANT_BITS_ADDR  address issued to instruction memory (registered)
- o_enable_mem  out  1  instruction-memory read enable; when 0, memory holds its output
- o_instruccion  out  CANT_BITS_INSTRUCCION  IF/ID instruction
- o_adder_pc  out  CANT_BITS_ADDR  IF/ID PC+1 of o_instruccion
- o_valid  out  1  IF/ID slot holds a real instruction (0 = squashed NOP)
- o_halt  out  1  HALT fetched; fetch stopped

## Operation
Internal registers:
- pc_reg: address being fetched; drives o_pc.
- fetch_pc: address whose data is on i_instruccion this cycle.
- state: one of FLUSH, RUN, HALT.

Control:
- advance = i_enable & ~i_stall & (state != HALT).
- o_enable_mem = advance; forced 0 while i_reset is low.

Per-state behaviour (all updates only when advance):
- FLUSH (reset state): IF/ID <= NOP (o_instruccion=0, o_valid=0); fetch_pc <= pc_reg; pc_reg <= pc_reg+1; state <= RUN. i_branch_control ignored.
- RUN, i_branch_control=1: IF/ID <= NOP; pc_reg <= i_branch_dir; fetch_pc unchanged; state <= FLUSH.
- RUN, no branch, i_instruccion == HALT_INSTRUCCION: IF/ID <= {HALT, fetch_pc+1, valid=1}; PC frozen; state <= HALT.
- RUN, otherwise: IF/ID <= {i_instruccion, fetch_pc+1, valid=1}; fetch_pc <= pc_reg; pc_reg <= pc_reg+1.
- HALT: on i_enable=1 (stall ignored), IF/ID <= NOP; pc_reg and fetch_pc frozen. Only reset exits HALT.

Priority: i_enable=0 > i_stall > branch > HALT detect > normal fetch.
- Stall with a simultaneous branch: the branch is ignored. ID re-presents it after the stall releases.
- HALT on i_instruccion in the same cycle as a taken branch: it is wrong-path and is squashed; no HALT entry.

Arithmetic: all PC additions are unsigned modulo 2^CANT_BITS_ADDR; 2^N-1 wraps to 0. i_branch_dir is taken verbatim.

## Timing
- Reset (async, i_reset=0), all outputs: o_pc=0, o_instruccion=0, o_adder_pc=0, o_valid=0, o_halt=0, o_enable_mem=0. Internal: fetch_pc=0, state=FLUSH. Reset mid-operation aborts any flush or halt immediately.
- After reset release, first advancing edge is the FLUSH slot. The instruction at address 0 is valid in IF/ID after the second advancing edge.
- Taken branch seen at edge t produces NOP in IF/ID at t and t+1. The target instruction is in IF/ID after edge t+2, with o_adder_pc = target+1.
- o_halt rises on the edge that captures HALT into IF/ID.
- Stall or i_enable=0 holds every register, including a FLUSH in progress.

## Structure
- Shared package: state encoding (FLUSH, RUN, HALT), NOP constant (all-zero), HALT_INSTRUCCION default.
- One sub-module: adder_signed, instantiated twice for pc_reg+1 and fetch_pc+1.
- Remainder is a single always block for registers plus combinational next-state logic.

## Test plan
- Reset release, memory model returning word = address, 4 advancing cycles: o_valid 0,1,1,1; o_instruccion 0,0,1,2; o_adder_pc —,1,2,3.
- i_branch_control=1 with i_branch_dir=0x40 while IF/ID holds word 5: next two IF/ID slots are NOP. Then o_instruccion=0x40, o_adder_pc=0x41, and o_pc sequence 0x40, 0x41, 0x42.
- i_stall=1 for 3 cycles together with i_branch_control=1: o_pc, IF/ID and o_enable_mem=0 held for 3 cycles, branch ignored. Branch taken on the first non-stalled cycle.
- HALT at address 7: o_halt=1 with o_instruccion=HALT and o_adder_pc=8. Afterwards IF/ID is NOP and o_pc never changes until reset. HALT as wrong-path word after a taken branch: o_halt stays 0.
- PC wrap: branch to 2^11-1, run 3 cycles: o_pc goes 0x7FF, 0x000, 0x001. IF/ID o_adder_pc shows 0x000 for the 0x7FF instruction.
- i_reset asserted asynchronously mid-FLUSH and while in HALT: all outputs go to reset values before the next clock edge. Operation restarts at address 0.
